// File: rtl/uart_pkg.sv
// uart_pkg: framing constants and FSM states shared by the UART transmitter and receiver
package uart_pkg;
  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int BAUD_DEF = 9600;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {st_idle, st_start, st_data, st_stop} uart_st_e;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer for the serial pin plus falling-edge detector
module uart_sync (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);
  logic s1, s2, h;
  // Resetting to 1 makes a line held low at reset release look like a start edge
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      h <= 1'b1;
    end else begin
      s1 <= rx;
      s2 <= s1;
      h <= s2;
    end
  end
  assign rx_s = s2;
  assign fall = h & ~s2;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with a byte strobe and framing-error strobe
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD = BAUD_DEF
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              rx_done,
  output logic              frame_err,
  output logic              busy_flag
);
  localparam int BIT_CNT_MAX = CLK_FREQ / BAUD;
  localparam int HALF_CNT = BIT_CNT_MAX / 2;
  localparam int CW = $clog2(BIT_CNT_MAX);
  uart_st_e state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [DATA_W-1:0] shift;
  logic rx_s, fall, tick_h, tick_b, shift_en, done_c, err_c;
  uart_sync u_sync (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .rx(rx),
    .rx_s(rx_s),
    .fall(fall)
  );
  assign tick_h = cnt == CW'(HALF_CNT - 1);
  assign tick_b = cnt == CW'(BIT_CNT_MAX - 1);
  // FSM state register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= st_idle;
    else state <= state_nxt;
  end
  // Next state: start qualified at half bit, data and stop sampled mid-bit
  always_comb begin
    state_nxt = state;
    case (state)
      st_idle:  state_nxt = fall ? st_start : st_idle;
      st_start: state_nxt = !tick_h ? st_start : rx_s ? st_idle : st_data;
      st_data:  state_nxt = (tick_b && bit_idx == 3'd7) ? st_stop : st_data;
      st_stop:  state_nxt = tick_b ? st_idle : st_stop;
      default:  state_nxt = st_idle;
    endcase
  end
  // FSM outputs: busy level and the per-sample strobes
  always_comb begin
    busy_flag = state != st_idle;
    shift_en = state == st_data && tick_b;
    done_c = state == st_stop && tick_b && rx_s;
    err_c = state == st_stop && tick_b && !rx_s;
  end
  // Baud counter, bit index, shift register and registered strobes
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      bit_idx <= 3'd0;
      shift <= '0;
      data_out <= '0;
      rx_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt <= (state == st_idle || state_nxt != state || tick_b) ? '0 : cnt + 1'b1;
      bit_idx <= state != st_data ? 3'd0 : shift_en ? bit_idx + 3'd1 : bit_idx;
      shift <= shift_en ? {rx_s, shift[DATA_W-1:1]} : shift;
      data_out <= done_c ? shift : data_out;
      rx_done <= done_c;
      frame_err <= err_c;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against an event-queue model of the receiver outputs
module tb_uart_rx;
  localparam int CF = 1600;
  localparam int BD = 100;
  localparam int MAX = CF / BD;
  localparam int HALF = MAX / 2;
  localparam int LAT = 3 + HALF + 9 * MAX;
  typedef struct {
    int b0;
    int b1;
    logic [7:0] d;
    int k;
  } ev_t;
  logic sys_clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic [7:0] data_out;
  logic rx_done, frame_err, busy_flag;
  int cyc = 0, nv = 0, nm = 0, n_done = 0, n_err = 0, busy_cnt = 0, last_done = 0;
  int s0, b0;
  ev_t q[$];
  logic [7:0] m_dout = 8'h00;
  uart_rx #(.CLK_FREQ(CF), .BAUD(BD)) dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .rx(rx),
    .data_out(data_out),
    .rx_done(rx_done),
    .frame_err(frame_err),
    .busy_flag(busy_flag)
  );
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nv++;
    if (act !== exp) begin
      nm++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, act, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input logic stp, input int n);
    logic [9:0] f;
    f = {stp, b, 1'b0};
    q.push_back(ev_t'{cyc + 3, cyc + LAT, b, stp ? 1 : 2});
    for (int i = 0; i < n; i++) begin
      rx = f[i];
      idle(MAX);
    end
  endtask
  initial begin
    logic eb, ed, ee, hit;
    forever begin
      @(negedge sys_clk);
      if (!rst_n) begin
        q.delete();
        m_dout = 8'h00;
        {eb, ed, ee, hit} = 4'b0;
      end else begin
        hit = q.size() > 0 && cyc == q[0].b1;
        eb = q.size() > 0 && cyc >= q[0].b0 && cyc < q[0].b1;
        ed = hit && q[0].k == 1;
        ee = hit && q[0].k == 2;
        if (ed) m_dout = q[0].d;
      end
      chk("rx_done", rx_done, ed);
      chk("frame_err", frame_err, ee);
      chk("busy_flag", busy_flag, eb);
      chk("data_out", data_out, m_dout);
      if (rx_done) begin
        n_done++;
        last_done = cyc;
      end
      if (frame_err) n_err++;
      if (busy_flag) busy_cnt++;
      if (hit) q.delete(0);
    end
  end
  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    idle(5);
    rst_n = 1'b1;
    idle(400);
    chk("idle_busy", busy_cnt, 0);
    chk("idle_done", n_done, 0);
    s0 = cyc;
    send(8'h55, 1'b1, 10);
    idle(20);
    chk("lat_55", last_done - s0, 155);
    chk("data_55", data_out, 8'h55);
    chk("cnt_55", n_done, 1);
    send(8'hB3, 1'b1, 10);
    idle(20);
    chk("data_b3", data_out, 8'hB3);
    chk("cnt_b3", n_done, 2);
    send(8'hA5, 1'b0, 10);
    rx = 1'b1;
    idle(20);
    chk("err_a5", n_err, 1);
    chk("done_a5", n_done, 2);
    chk("hold_a5", data_out, 8'hB3);
    b0 = busy_cnt;
    q.push_back(ev_t'{cyc + 3, cyc + 3 + HALF, 8'h00, 0});
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(40);
    chk("glitch_busy", busy_cnt - b0, 8);
    chk("glitch_pulses", n_done + n_err, 3);
    send(8'h55, 1'b1, 10);
    send(8'hB3, 1'b1, 10);
    send(8'h00, 1'b1, 10);
    idle(20);
    chk("b2b_cnt", n_done, 5);
    chk("b2b_data", data_out, 8'h00);
    send(8'h3C, 1'b1, 4);
    rx = 1'b1;
    idle(HALF);
    rst_n = 1'b0;
    idle(1);
    chk("rst_busy", busy_flag, 0);
    chk("rst_pulses", {rx_done, frame_err}, 0);
    idle(5);
    rst_n = 1'b1;
    idle(20);
    send(8'hC3, 1'b1, 10);
    idle(20);
    chk("data_c3", data_out, 8'hC3);
    chk("cnt_c3", n_done, 6);
    rst_n = 1'b0;
    rx = 1'b0;
    idle(5);
    rst_n = 1'b1;
    q.push_back(ev_t'{cyc + 3, cyc + LAT, 8'h00, 2});
    idle(200);
    rx = 1'b1;
    idle(40);
    chk("low_rel_err", n_err, 2);
    chk("low_rel_data", data_out, 8'h00);
    chk("low_rel_done", n_done, 6);
    $display("== %0d vectors applied, %0d miscompares ==", nv, nm);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for 8N1 serial frames, LSB first, at a fixed baud rate derived from the system clock. It is the counterpart of the existing `TX` transmitter and uses the same clock, reset and framing. The block samples the asynchronous `rx` pin and presents each received byte on a parallel bus with a one-cycle strobe. It sits between the board UART pin and the application logic (loopback, command parsing).

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate in bits/s.
- `sys_clk` input 1: system clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx` input 1: serial line, asynchronous to `sys_clk`; idles high.
- `data_out` output 8: last correctly framed byte; held between frames.
- `rx_done` output 1: one-cycle pulse; `data_out` is valid in the same cycle.
- `frame_err` output 1: one-cycle pulse when the stop bit samples low.
- `busy_flag` output 1: high while a frame is being received (any state other than IDLE).

## Operation
- Derived constant `BIT_CNT_MAX = CLK_FREQ/BAUD` (integer division; 5208 at the defaults). `HALF_CNT = BIT_CNT_MAX/2`.
- Input conditioning: `rx` passes through 2 synchronizer flops plus 1 history flop, all with reset value 1. A falling edge is history=1 and sync=0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a falling edge, go to START and clear the baud counter.
  - START: at count `HALF_CNT-1`, sample. If the sample is 1 (glitch or false start), return to IDLE with no pulse. If it is 0, go to DATA and clear the counter.
  - DATA: at count `BIT_CNT_MAX-1`, which is mid-bit, sample and shift right into the MSB of a shift register, so LSB-first lands correctly. After the 8th sample, go to STOP.
  - STOP: at count `BIT_CNT_MAX-1`, sample.
    - If 1: load `data_out` from the shift register and pulse `rx_done`.
    - If 0: pulse `frame_err` and leave `data_out` unchanged.
    - In both cases go to IDLE in the same cycle.
- Baud counter: width `$clog2(BIT_CNT_MAX)`. It wraps to 0 at the terminal count and is held at 0 in IDLE.
- Bit index: 3 bits, 0..7, cleared on entry to DATA.

## Timing
- Reset values: `data_out`=8'h00, `rx_done`=0, `frame_err`=0, `busy_flag`=0. FSM is in IDLE; counters and shift register are 0.
- Edge detect lags the pin by 2–3 cycles because of synchronization.
- `rx_done` and `frame_err` assert about 9.5 bit periods after the start edge, i.e. mid stop bit: (`HALF_CNT` + 9·`BIT_CNT_MAX`) cycles after the edge is detected.
- Both pulses last exactly one cycle and are mutually exclusive.
- `busy_flag` rises the cycle after the edge is detected and falls in the same cycle as `rx_done` or `frame_err`, or on a false-start abort.
- Back-to-back frames: returning to IDLE mid stop bit leaves half a bit period to catch the next start edge. Zero inter-frame gap must be received without loss.
- Falling edges while not in IDLE are ignored.
- `rx` low at reset release: the reset value 1 of the history flop makes this look like an edge. The block receives 8'h00 with `frame_err`, then waits for the line to go high before accepting a new edge.
- Reset asserted mid-frame: all state returns to reset values immediately and no pulse is issued. After release, a new frame needs a fresh falling edge.
- No parity, no FIFO. `data_out` is overwritten by the next good frame whether or not the consumer has read it.

## Structure
- Shared package `uart_pkg` holds:
  - `CLK_FREQ_DEF` and `BAUD_DEF`;
  - the `DATA_W`=8 constant;
  - the FSM state enum (`st_idle`, `st_start`, `st_data`, `st_stop`), so `TX` and `uart_rx` agree on framing.
- One sub-module: `uart_sync`, the 2-flop synchronizer plus falling-edge detector. The baud counter and FSM stay inline.

## Test plan
- Idle line after reset: `rx`=1 for 2 ms. Required: no `rx_done`, no `frame_err`; `busy_flag`=0 and `data_out`=8'h00 throughout.
- Drive frame 8'h55 at 9600 baud. Required: a single `rx_done` at about 989.6 µs after the start edge, `data_out`=8'h55. Then repeat with 8'hB3 and require `data_out`=8'hB3.
- Loopback: connect `TX.tx` to `rx`. Send 8'h55, 8'hB3 and 8'h00 back-to-back, restarting `TX` as soon as its `busy_flag` drops. Required: three `rx_done` pulses with matching `data_out` values.
- 20 µs low glitch on an idle line. Required: the abort occurs in START; `busy_flag` pulses high for about 52 µs; no `rx_done`, no `frame_err`.
- Frame 8'hA5 with the stop bit forced to 0. Required: `frame_err` for 1 cycle, no `rx_done`, and `data_out` keeps its previous value.
- Assert `rst_n`=0 during the 4th data bit of 8'h3C, release after 1 µs, then send 8'hC3. Required: all outputs at reset values during reset; the next `rx_done` carries 8'hC3.
